// File: rtl/conv_stream_feeder.sv
// Streams packed staging-memory words out over three independent valid/ready lanes (a, b, c).
// Optional macro CONV_STREAM_FEEDER_PERF_EN adds the stall_cycles performance counter output.
module conv_stream_feeder #(
    parameter int IO_DATA_WIDTH = 16,
    parameter int ADDR_WIDTH    = 20,
    parameter int COUNT_WIDTH   = 20,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                       clk,
    input  logic                       rst_in,
    input  logic                       start,
    input  logic [ADDR_WIDTH-1:0]      base_addr,
    input  logic [COUNT_WIDTH-1:0]     nb_words,
    input  logic [2:0]                 lane_mask,
    output logic                       running,
    output logic                       done,
    output logic                       mem_read_en,
    output logic [ADDR_WIDTH-1:0]      mem_read_addr,
    input  logic [3*IO_DATA_WIDTH-1:0] mem_qout,
    output logic [IO_DATA_WIDTH-1:0]   a_data,
    output logic [IO_DATA_WIDTH-1:0]   b_data,
    output logic [IO_DATA_WIDTH-1:0]   c_data,
    output logic                       a_valid,
    output logic                       b_valid,
    output logic                       c_valid,
    input  logic                       a_ready,
    input  logic                       b_ready,
    input  logic                       c_ready
`ifdef CONV_STREAM_FEEDER_PERF_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int WORD_W = 3 * IO_DATA_WIDTH;
    localparam int PTR_W  = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0]  base_q;
    logic [COUNT_WIDTH-1:0] nb_q;
    logic [2:0]             mask_q;
    logic [COUNT_WIDTH-1:0] issue_cnt;
    logic [COUNT_WIDTH-1:0] pop_cnt;
    logic [2:0]             lane_done;
    logic                   inflight;

    logic [WORD_W-1:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;
    logic [CNT_W-1:0]       fifo_count;

    logic                   in_run;
    logic                   head_ok;
    logic [2:0]             lane_ready;
    logic [2:0]             lane_valid;
    logic [2:0]             lane_hs;
    logic                   pop_now;
    logic [CNT_W:0]         occ_next;
    logic [WORD_W-1:0]      head;
    logic                   accept_start;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign accept_start = (state == ST_IDLE) && start;
    assign in_run       = (state == ST_RUN);
    assign head_ok      = in_run && (fifo_count != '0);
    assign head         = fifo_mem[rd_ptr];
    assign lane_ready   = {c_ready, b_ready, a_ready};
    assign lane_valid   = head_ok ? (mask_q & ~lane_done) : 3'b000;
    assign lane_hs      = lane_valid & lane_ready;

    // A word retires once every lane is masked off, already accepted, or accepting now.
    assign pop_now  = head_ok && (&(~mask_q | lane_done | lane_hs));

    // Occupancy the FIFO will have once the outstanding read lands, net of this cycle's pop.
    assign occ_next = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop_now);

    assign mem_read_en   = in_run && (issue_cnt < nb_q) && (occ_next < (CNT_W+1)'(FIFO_DEPTH));
    assign mem_read_addr = base_q + ADDR_WIDTH'(issue_cnt);

    assign a_data  = head[IO_DATA_WIDTH-1:0];
    assign b_data  = head[2*IO_DATA_WIDTH-1:IO_DATA_WIDTH];
    assign c_data  = head[3*IO_DATA_WIDTH-1:2*IO_DATA_WIDTH];
    assign a_valid = lane_valid[0];
    assign b_valid = lane_valid[1];
    assign c_valid = lane_valid[2];

    assign running = (state == ST_RUN) || (state == ST_DONE);
    assign done    = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Completion looks at the post-pop count so done follows the final handshake by one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if ((pop_cnt + COUNT_WIDTH'(pop_now)) == nb_q) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            base_q     <= '0;
            nb_q       <= '0;
            mask_q     <= '0;
            issue_cnt  <= '0;
            pop_cnt    <= '0;
            lane_done  <= '0;
            inflight   <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            if (accept_start) begin
                base_q    <= base_addr;
                nb_q      <= nb_words;
                mask_q    <= lane_mask;
                issue_cnt <= '0;
                pop_cnt   <= '0;
                lane_done <= '0;
            end else begin
                if (mem_read_en) begin
                    issue_cnt <= issue_cnt + COUNT_WIDTH'(1);
                end
                if (pop_now) begin
                    pop_cnt   <= pop_cnt + COUNT_WIDTH'(1);
                    lane_done <= '0;
                end else begin
                    lane_done <= lane_done | lane_hs;
                end
            end

            inflight <= mem_read_en;
            if (inflight) begin
                fifo_mem[wr_ptr] <= mem_qout;
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop_now) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            fifo_count <= fifo_count + CNT_W'(inflight) - CNT_W'(pop_now);
        end
    end

`ifdef CONV_STREAM_FEEDER_PERF_EN
    logic stall_now;

    assign stall_now = head_ok && (|(lane_valid & ~lane_ready)) && !pop_now;

    always_ff @(posedge clk) begin
        if (rst_in) begin
            stall_cycles <= '0;
        end else if (accept_start) begin
            stall_cycles <= '0;
        end else if (stall_now && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_conv_stream_feeder.sv
// Directed self-checking bench for conv_stream_feeder with a 1-cycle-latency staging memory model.
// Cycle k below is the k-th cycle after the edge that samples start.
module tb_conv_stream_feeder;

    localparam int IO = 16;
    localparam int AW = 20;
    localparam int CW = 20;

    logic          clk = 1'b0;
    logic          rst_in = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [CW-1:0] nb_words = '0;
    logic [2:0]    lane_mask = '0;
    logic          running;
    logic          done;
    logic          mem_read_en;
    logic [AW-1:0] mem_read_addr;
    logic [3*IO-1:0] mem_qout = '0;
    logic [IO-1:0] a_data, b_data, c_data;
    logic          a_valid, b_valid, c_valid;
    logic          a_ready = 1'b0;
    logic          b_ready = 1'b0;
    logic          c_ready = 1'b0;
`ifdef CONV_STREAM_FEEDER_PERF_EN
    logic [31:0]   stall_cycles;
`endif

    int checks = 0;
    int passes = 0;

    logic [AW-1:0] addr_q [$];
    logic [IO-1:0] a_q [$];
    logic [IO-1:0] b_q [$];
    logic [IO-1:0] c_q [$];
    int            a_cyc_q [$];
    logic [2:0]    vld_log [64];
    logic [IO-1:0] bdat_log [64];
    int            rd_cnt_log [64];
    logic [2:0]    vld_or;
    int            done_cyc;
    int            done_pulses;
    int            run_cycles;

    always #5 clk = ~clk;

    conv_stream_feeder #(
        .IO_DATA_WIDTH(IO),
        .ADDR_WIDTH(AW),
        .COUNT_WIDTH(CW),
        .FIFO_DEPTH(2)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .start(start),
        .base_addr(base_addr),
        .nb_words(nb_words),
        .lane_mask(lane_mask),
        .running(running),
        .done(done),
        .mem_read_en(mem_read_en),
        .mem_read_addr(mem_read_addr),
        .mem_qout(mem_qout),
        .a_data(a_data),
        .b_data(b_data),
        .c_data(c_data),
        .a_valid(a_valid),
        .b_valid(b_valid),
        .c_valid(c_valid),
        .a_ready(a_ready),
        .b_ready(b_ready),
        .c_ready(c_ready)
`ifdef CONV_STREAM_FEEDER_PERF_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    // Memory content: the word at 0x10+k is {k+3, k+2, k+1}.
    function automatic logic [3*IO-1:0] word_of(input logic [AW-1:0] addr);
        logic [IO-1:0] k;
        k = addr[IO-1:0] - 16'h0010;
        return {k + 16'd3, k + 16'd2, k + 16'd1};
    endfunction

    always @(posedge clk) begin
        if (mem_read_en) begin
            mem_qout <= word_of(mem_read_addr);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Starts a transfer and logs reads, handshakes and valids until done or the budget runs out.
    task automatic run_transfer(input logic [AW-1:0] base, input logic [CW-1:0] nb,
                                input logic [2:0] mask, input int stall_lo, input int stall_hi,
                                input int budget);
        addr_q.delete(); a_q.delete(); b_q.delete(); c_q.delete(); a_cyc_q.delete();
        for (int i = 0; i < 64; i++) begin
            vld_log[i] = '0; bdat_log[i] = '0; rd_cnt_log[i] = 0;
        end
        vld_or = '0; done_cyc = 0; done_pulses = 0; run_cycles = 0;
        start = 1'b1; base_addr = base; nb_words = nb; lane_mask = mask;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= budget && k < 64; k++) begin
            a_ready = 1'b1;
            c_ready = 1'b1;
            b_ready = !(k >= stall_lo && k <= stall_hi);
            @(negedge clk);
            if (mem_read_en) addr_q.push_back(mem_read_addr);
            rd_cnt_log[k] = addr_q.size();
            vld_log[k] = {c_valid, b_valid, a_valid};
            vld_or = vld_or | vld_log[k];
            bdat_log[k] = b_data;
            if (running) run_cycles++;
            if (a_valid && a_ready) begin a_q.push_back(a_data); a_cyc_q.push_back(k); end
            if (b_valid && b_ready) b_q.push_back(b_data);
            if (c_valid && c_ready) c_q.push_back(c_data);
            if (done) begin
                done_pulses++;
                if (done_cyc == 0) done_cyc = k;
            end
            @(posedge clk); #1;
            if (done_cyc != 0) break;
        end
    endtask

    task automatic test_reset();
        rst_in = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (running !== 1'b0) $display("[TB] FAIL reset_running: got %b expected 0", running); else passes++;
        checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passes++;
        checks++; if (mem_read_en !== 1'b0) $display("[TB] FAIL reset_read_en: got %b expected 0", mem_read_en); else passes++;
        checks++; if ({c_valid, b_valid, a_valid} !== 3'b000) $display("[TB] FAIL reset_valids: got %b expected 000", {c_valid, b_valid, a_valid}); else passes++;
        checks++; if (a_data !== 16'h0) $display("[TB] FAIL reset_a_data: got %h expected 0000", a_data); else passes++;
        checks++; if (mem_read_addr !== 20'h0) $display("[TB] FAIL reset_read_addr: got %h expected 00000", mem_read_addr); else passes++;
        @(posedge clk); #1;
        rst_in = 1'b0;
    endtask

    task automatic test_basic_stream();
        logic [IO-1:0] a_got;
        run_transfer(20'h00010, 20'd4, 3'b111, 0, -1, 40);
        checks++; if (done_cyc !== 7) $display("[TB] FAIL basic_done_cycle: got %0d expected 7", done_cyc); else passes++;
        checks++; if (run_cycles !== 7) $display("[TB] FAIL basic_running_cycles: got %0d expected 7", run_cycles); else passes++;
        checks++; if (done_pulses !== 1) $display("[TB] FAIL basic_done_pulses: got %0d expected 1", done_pulses); else passes++;
        checks++; if (rd_cnt_log[4] !== 4) $display("[TB] FAIL basic_reads_by_cycle4: got %0d expected 4", rd_cnt_log[4]); else passes++;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= addr_q.size() || addr_q[i] !== 20'h00010 + 20'(i))
                $display("[TB] FAIL basic_read_addr[%0d]: got %h expected %h", i, (i < addr_q.size()) ? addr_q[i] : 20'hxxxxx, 20'h00010 + 20'(i));
            else passes++;
            a_got = (i < a_q.size()) ? a_q[i] : 16'hxxxx;
            checks++;
            if (a_got !== 16'(i + 1) || a_cyc_q[i] !== i + 3)
                $display("[TB] FAIL basic_a_hs[%0d]: got data %h in cycle %0d expected %h in cycle %0d", i, a_got, (i < a_cyc_q.size()) ? a_cyc_q[i] : -1, 16'(i + 1), i + 3);
            else passes++;
        end
        checks++; if (b_q.size() !== 4 || c_q.size() !== 4) $display("[TB] FAIL basic_bc_hs_count: got %0d/%0d expected 4/4", b_q.size(), c_q.size()); else passes++;
    endtask

    task automatic test_backpressure();
        run_transfer(20'h00010, 20'd4, 3'b111, 3, 7, 40);
        checks++; if (done_cyc !== 12) $display("[TB] FAIL bp_done_cycle: got %0d expected 12", done_cyc); else passes++;
        checks++; if (rd_cnt_log[7] !== 2) $display("[TB] FAIL bp_reads_during_stall: got %0d expected 2", rd_cnt_log[7]); else passes++;
        for (int k = 3; k <= 7; k++) begin
            checks++;
            if (vld_log[k] !== ((k == 3) ? 3'b111 : 3'b010) || bdat_log[k] !== 16'd2)
                $display("[TB] FAIL bp_hold_cycle%0d: got valids %b b_data %h expected %b/0002", k, vld_log[k], bdat_log[k], (k == 3) ? 3'b111 : 3'b010);
            else passes++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (i >= a_q.size() || i >= b_q.size() || i >= c_q.size() ||
                a_q[i] !== 16'(i + 1) || b_q[i] !== 16'(i + 2) || c_q[i] !== 16'(i + 3))
                $display("[TB] FAIL bp_word%0d: got sizes %0d/%0d/%0d expected a,b,c = %0d,%0d,%0d", i, a_q.size(), b_q.size(), c_q.size(), i + 1, i + 2, i + 3);
            else passes++;
        end
`ifdef CONV_STREAM_FEEDER_PERF_EN
        checks++; if (stall_cycles !== 32'd5) $display("[TB] FAIL bp_stall_cycles: got %0d expected 5", stall_cycles); else passes++;
`endif
    endtask

    task automatic test_zero_words();
        run_transfer(20'h00010, 20'd0, 3'b111, 0, -1, 20);
        checks++; if (done_cyc !== 2) $display("[TB] FAIL zero_done_cycle: got %0d expected 2", done_cyc); else passes++;
        checks++; if (addr_q.size() !== 0) $display("[TB] FAIL zero_reads: got %0d expected 0", addr_q.size()); else passes++;
        checks++; if (vld_or !== 3'b000) $display("[TB] FAIL zero_valids: got %b expected 000", vld_or); else passes++;
    endtask

    task automatic test_addr_wrap();
        logic [3*IO-1:0] w;
        logic [AW-1:0] exp_addr [3];
        exp_addr[0] = 20'hFFFFE; exp_addr[1] = 20'hFFFFF; exp_addr[2] = 20'h00000;
        run_transfer(20'hFFFFE, 20'd3, 3'b111, 0, -1, 30);
        checks++; if (done_cyc !== 6) $display("[TB] FAIL wrap_done_cycle: got %0d expected 6", done_cyc); else passes++;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (i >= addr_q.size() || addr_q[i] !== exp_addr[i])
                $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", i, (i < addr_q.size()) ? addr_q[i] : 20'hxxxxx, exp_addr[i]);
            else passes++;
        end
        w = word_of(20'h00000);
        checks++;
        if (a_q.size() !== 3 || a_q[2] !== w[IO-1:0])
            $display("[TB] FAIL wrap_last_a_data: got size %0d expected 3 with last %h", a_q.size(), w[IO-1:0]);
        else passes++;
    endtask

    task automatic test_lane_mask();
        run_transfer(20'h00010, 20'd2, 3'b010, 0, -1, 30);
        checks++; if ((vld_or & 3'b101) !== 3'b000) $display("[TB] FAIL mask_b_only_valids: got %b expected 0x0", vld_or); else passes++;
        checks++;
        if (b_q.size() !== 2 || b_q[0] !== 16'd2 || b_q[1] !== 16'd3)
            $display("[TB] FAIL mask_b_hs: got %0d handshakes expected 2 with data 2,3", b_q.size());
        else passes++;
        checks++; if (done_cyc !== 5) $display("[TB] FAIL mask_b_done_cycle: got %0d expected 5", done_cyc); else passes++;

        run_transfer(20'h00010, 20'd5, 3'b000, 0, -1, 30);
        checks++; if (addr_q.size() !== 5) $display("[TB] FAIL drain_reads: got %0d expected 5", addr_q.size()); else passes++;
        checks++; if (vld_or !== 3'b000) $display("[TB] FAIL drain_valids: got %b expected 000", vld_or); else passes++;
        checks++; if (done_cyc !== 8) $display("[TB] FAIL drain_done_cycle: got %0d expected 8", done_cyc); else passes++;
    endtask

    task automatic test_reset_mid_transfer();
        int stray_done;
        a_ready = 1'b0; b_ready = 1'b0; c_ready = 1'b0;
        start = 1'b1; base_addr = 20'h00010; nb_words = 20'd4; lane_mask = 3'b111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({c_valid, b_valid, a_valid} !== 3'b111) $display("[TB] FAIL rstmid_first_valid: got %b expected 111", {c_valid, b_valid, a_valid}); else passes++;
        @(posedge clk); #1;
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        @(negedge clk);
        checks++; if ({c_valid, b_valid, a_valid} !== 3'b000) $display("[TB] FAIL rstmid_valids: got %b expected 000", {c_valid, b_valid, a_valid}); else passes++;
        checks++; if (running !== 1'b0) $display("[TB] FAIL rstmid_running: got %b expected 0", running); else passes++;
        stray_done = 0;
        for (int k = 0; k < 4; k++) begin
            if (done) stray_done++;
            @(negedge clk);
        end
        checks++; if (stray_done !== 0) $display("[TB] FAIL rstmid_no_done: got %0d pulses expected 0", stray_done); else passes++;
        @(posedge clk); #1;

        run_transfer(20'h00010, 20'd4, 3'b111, 0, -1, 40);
        checks++;
        if (addr_q.size() !== 4 || addr_q[0] !== 20'h00010)
            $display("[TB] FAIL rstmid_restart_addr: got %0d reads expected 4 from 00010", addr_q.size());
        else passes++;
        checks++;
        if (a_q.size() !== 4 || a_q[0] !== 16'd1)
            $display("[TB] FAIL rstmid_restart_a_data: got %0d handshakes expected 4 starting at 0001", a_q.size());
        else passes++;
        checks++; if (done_cyc !== 7) $display("[TB] FAIL rstmid_restart_done: got %0d expected 7", done_cyc); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_backpressure();
        test_zero_words();
        test_addr_wrap();
        test_lane_mask();
        test_reset_mid_transfer();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
